mux4to1: RTL and testbench

MUX4TO1 -- requirements
Module: mux4to1

---
 rtl/mux4to1.sv | 81 ++++++++
 tb/tb_mux4to1.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux4to1.sv
// 4:1 multiplexer built three independent ways (case, if/else chain, gates),
// with a registered copy of the case result and a registered disagreement flag.
module mux4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out_q,
  output logic             mismatch
);

  always_comb begin
    out0 = '0;
    case (sel)
      2'd0:    out0 = in0;
      2'd1:    out0 = in1;
      2'd2:    out0 = in2;
      2'd3:    out0 = in3;
      default: out0 = '0;
    endcase
  end

  always_comb begin
    out1 = '0;
    if (sel == 2'd0)
      out1 = in0;
    else if (sel == 2'd1)
      out1 = in1;
    else if (sel == 2'd2)
      out1 = in2;
    else if (sel == 2'd3)
      out1 = in3;
    else
      out1 = '0;
  end

  // Gate-level form: one-hot decode of sel, then AND-OR per data bit.
  wire       sel0_n;
  wire       sel1_n;
  wire [3:0] dec;
  wire [WIDTH-1:0] gate_out;

  not u_inv0 (sel0_n, sel[0]);
  not u_inv1 (sel1_n, sel[1]);
  and u_dec0 (dec[0], sel1_n, sel0_n);
  and u_dec1 (dec[1], sel1_n, sel[0]);
  and u_dec2 (dec[2], sel[1], sel0_n);
  and u_dec3 (dec[3], sel[1], sel[0]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire [3:0] term;
    and u_and0 (term[0], in0[i], dec[0]);
    and u_and1 (term[1], in1[i], dec[1]);
    and u_and2 (term[2], in2[i], dec[2]);
    and u_and3 (term[3], in3[i], dec[3]);
    or  u_or   (gate_out[i], term[0], term[1], term[2], term[3]);
  end

  assign out2 = gate_out;

  // An unknown sel leaves the outputs meaningless, so the flag keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      mismatch <= 1'b0;
    end else begin
      out_q <= out0;
      if (!$isunknown(sel))
        mismatch <= (out0 != out1) | (out0 != out2);
    end
  end

endmodule

// File: tb/tb_mux4to1.sv
// Self-checking bench for mux4to1: a 1-bit and a 4-bit instance checked
// against an array-indexing reference model.
module tb_mux4to1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel_a = '0;
  logic       a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
  logic       ao0, ao1, ao2, aq, amis;
  logic [1:0] sel_b = '0;
  logic [3:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic [3:0] bo0, bo1, bo2, bq;
  logic       bmis;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel_a),
    .in0(a0), .in1(a1), .in2(a2), .in3(a3),
    .out0(ao0), .out1(ao1), .out2(ao2), .out_q(aq), .mismatch(amis)
  );

  mux4to1 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sel(sel_b),
    .in0(b0), .in1(b1), .in2(b2), .in3(b3),
    .out0(bo0), .out1(bo1), .out2(bo2), .out_q(bq), .mismatch(bmis)
  );

  // Reference: the selected input is simply the array element at index sel.
  function automatic logic [3:0] ref_mux(logic [1:0] s, logic [3:0] i0, logic [3:0] i1,
                                         logic [3:0] i2, logic [3:0] i3);
    logic [3:0] pool [4];
    pool = '{i0, i1, i2, i3};
    return pool[s];
  endfunction

  task automatic check(string tag, logic [3:0] observed, logic [3:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_comb1(string tag);
    logic [3:0] exp_v;
    exp_v = ref_mux(sel_a, {3'b0, a0}, {3'b0, a1}, {3'b0, a2}, {3'b0, a3});
    check({tag, ".out0"}, {3'b0, ao0}, exp_v);
    check({tag, ".out1"}, {3'b0, ao1}, exp_v);
    check({tag, ".out2"}, {3'b0, ao2}, exp_v);
  endtask

  task automatic apply1(logic [5:0] v);
    @(negedge clk);
    {sel_a, a3, a2, a1, a0} = v;
    #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [5:0] vec;
    logic [3:0] exp_v;
    logic [3:0] pat [4];
    logic [3:0] prev_q;

    #1;
    check("reset.a_out_q", {3'b0, aq}, 4'h0);
    check("reset.a_mismatch", {3'b0, amis}, 4'h0);
    check("reset.b_out_q", bq, 4'h0);
    check("reset.b_mismatch", {3'b0, bmis}, 4'h0);
    a0 = 1'b1;
    #1;
    check_comb1("reset_track");
    @(posedge clk);
    #1;
    check("reset_hold.a_out_q", {3'b0, aq}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply1(6'b00_0001);
    check_comb1("basic_sel0_one");
    apply1(6'b00_1110);
    check_comb1("basic_sel0_zero");

    apply1(6'b01_0010); check_comb1("onehot_sel1");
    apply1(6'b10_0100); check_comb1("onehot_sel2");
    apply1(6'b11_1000); check_comb1("onehot_sel3");
    apply1(6'b01_1101); check_comb1("inv_sel1");
    apply1(6'b10_1011); check_comb1("inv_sel2");
    apply1(6'b11_0111); check_comb1("inv_sel3");

    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      vec = 6'($urandom);
      {sel_a, a3, a2, a1, a0} = vec;
      #50;
      check_comb1($sformatf("rand%0d", k));
      exp_v = ref_mux(sel_a, {3'b0, a0}, {3'b0, a1}, {3'b0, a2}, {3'b0, a3});
      check($sformatf("rand%0d.out_q", k), {3'b0, aq}, exp_v);
      check($sformatf("rand%0d.mismatch", k), {3'b0, amis}, 4'h0);
    end

    // Asynchronous reset while out_q holds 1.
    apply1(6'b00_0001);
    @(posedge clk);
    #2;
    check("pre_reset.out_q", {3'b0, aq}, 4'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset.out_q", {3'b0, aq}, 4'h0);
    check("async_reset.mismatch", {3'b0, amis}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    {sel_a, a3, a2, a1, a0} = 6'b10_0100;
    #1;
    check("release.out_q_before_edge", {3'b0, aq}, 4'h0);
    @(posedge clk);
    #1;
    check("release.out_q_after_edge", {3'b0, aq}, 4'h1);

    // Wide sweep on the 4-bit instance.
    pat = '{4'hA, 4'h5, 4'hF, 4'h0};
    @(negedge clk);
    {b0, b1, b2, b3} = {pat[0], pat[1], pat[2], pat[3]};
    sel_b = 2'd0;
    @(posedge clk);
    #1;
    prev_q = ref_mux(2'd0, b0, b1, b2, b3);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel_b = 2'(s);
      #1;
      exp_v = ref_mux(sel_b, b0, b1, b2, b3);
      check($sformatf("wide_sel%0d.out0", s), bo0, exp_v);
      check($sformatf("wide_sel%0d.out1", s), bo1, exp_v);
      check($sformatf("wide_sel%0d.out2", s), bo2, exp_v);
      check($sformatf("wide_sel%0d.out_q_before", s), bq, prev_q);
      @(posedge clk);
      #1;
      check($sformatf("wide_sel%0d.out_q_after", s), bq, exp_v);
      check($sformatf("wide_sel%0d.mismatch", s), {3'b0, bmis}, 4'h0);
      prev_q = exp_v;
    end

    // Forced disagreement between implementations for one cycle.
    apply1(6'b00_0001);
    force dut1.out1 = 1'b0;
    @(posedge clk);
    #1;
    check("forced.mismatch_set", {3'b0, amis}, 4'h1);
    @(negedge clk);
    release dut1.out1;
    a3 = 1'b1;
    #1;
    check_comb1("released");
    @(posedge clk);
    #1;
    check("released.mismatch_clear", {3'b0, amis}, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
